// File: rtl/sy_pkg.sv
// Shared types for the fetch/decode front end.
package sy_pkg;
  localparam int AWTH = 39;
  localparam int IWTH = 32;

  localparam logic [63:0] INSTR_PAGE_FAULT = 64'd12;
  localparam logic [63:0] ILLEGAL_INSTR    = 64'd2;

  typedef struct packed {
    logic        valid;
    logic [63:0] cause;
    logic [63:0] tval;
  } exception_t;

  typedef struct packed {
    logic [IWTH-1:0] instr;
    logic [AWTH-1:0] pc;
    logic            ex;
  } qentry_t;
endpackage

// File: rtl/sy_ppl_compress_dec.sv
// RVC expander: rewrites a compressed instruction into its 32-bit form.
// Encodings outside the supported base subset are reported as illegal.
module sy_ppl_compress_dec (
  input  logic [31:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_o,
  output logic        is_compressed_o
);
  always_comb begin
    instr_o         = instr_i;
    illegal_o       = 1'b0;
    is_compressed_o = instr_i[1:0] != 2'b11;
    if (is_compressed_o) begin
      instr_o = {16'b0, instr_i[15:0]};
      case ({instr_i[1:0], instr_i[15:13]})
        5'b00_000: begin // c.addi4spn; zero immediate is the canonical illegal word
          instr_o   = {2'b0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                       5'd2, 3'b000, 2'b01, instr_i[4:2], 7'b0010011};
          illegal_o = instr_i[12:5] == 8'b0;
        end
        5'b00_010: instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00,
                              2'b01, instr_i[9:7], 3'b010, 2'b01, instr_i[4:2], 7'b0000011};
        5'b00_110: instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2],
                              2'b01, instr_i[9:7], 3'b010, instr_i[11:10], instr_i[6], 2'b00,
                              7'b0100011};
        5'b01_000: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7],
                              3'b000, instr_i[11:7], 7'b0010011};
        5'b01_010: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'd0,
                              3'b000, instr_i[11:7], 7'b0010011};
        5'b01_101: instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                              instr_i[2], instr_i[11], instr_i[5:3], instr_i[12],
                              {8{instr_i[12]}}, 5'd0, 7'b1101111};
        5'b10_000: instr_o = {6'b0, instr_i[12], instr_i[6:2], instr_i[11:7], 3'b001,
                              instr_i[11:7], 7'b0010011};
        5'b10_100: begin
          if (instr_i[6:2] == 5'd0) begin
            if (instr_i[12] && instr_i[11:7] == 5'd0) instr_o = 32'h0010_0073;
            else begin
              instr_o   = {12'b0, instr_i[11:7], 3'b000, 4'b0, instr_i[12], 7'b1100111};
              illegal_o = !instr_i[12] && instr_i[11:7] == 5'd0;
            end
          end else begin
            instr_o = {7'b0, instr_i[6:2], instr_i[12] ? instr_i[11:7] : 5'd0, 3'b000,
                       instr_i[11:7], 7'b0110011};
          end
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/sy_ppl_instr_queue_mw.sv
// Multi-lane fetch->decode instruction queue: compacts valid fetch lanes into
// a circular buffer and presents an in-order prefix of entries to decode.
module sy_ppl_instr_queue_mw
  import sy_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int DEC_WIDTH   = 2,
  parameter int DEPTH       = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [FETCH_WIDTH-1:0]               fet_valid_i,
  input  logic [FETCH_WIDTH-1:0][63:0]         fet_addr_i,
  input  logic [FETCH_WIDTH-1:0][31:0]         fet_instr_i,
  input  logic [FETCH_WIDTH-1:0]               fet_ex_i,
  output logic                                 ready_o,
  output logic [DEC_WIDTH-1:0]                 dec_valid_o,
  input  logic [DEC_WIDTH-1:0]                 dec_ready_i,
  output logic [DEC_WIDTH-1:0][AWTH-1:0]       dec_pc_o,
  output logic [DEC_WIDTH-1:0][AWTH-1:0]       dec_npc_o,
  output logic [DEC_WIDTH-1:0][IWTH-1:0]       dec_instr_o,
  output logic [DEC_WIDTH-1:0]                 dec_is_compressed_o,
  output exception_t [DEC_WIDTH-1:0]           dec_ex_o,
  output logic [$clog2(DEPTH):0]               usage_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  qentry_t                       mem [DEPTH];
  logic [PW-1:0]                 head, tail;
  logic [CW-1:0]                 count, n_push, n_pop;
  logic [FETCH_WIDTH-1:0][CW-1:0] offs;
  logic                          push, pop_run;
  logic                          unused_addr;

  assign unused_addr = ^fet_addr_i;
  assign ready_o     = (CW'(DEPTH) - count) >= CW'(FETCH_WIDTH);
  assign usage_o     = count;
  assign push        = ready_o && |fet_valid_i && !flush_i;

  // Exclusive prefix popcount gives each valid lane its slot past tail.
  always_comb begin
    n_push = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      offs[l] = n_push;
      n_push  = n_push + CW'(fet_valid_i[l]);
    end
  end

  // A ready gap ends the pop run; later lanes stay queued.
  always_comb begin
    n_pop   = '0;
    pop_run = 1'b1;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      pop_run = pop_run && dec_valid_o[i] && dec_ready_i[i];
      n_pop   = n_pop + CW'(pop_run);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      for (int l = 0; l < FETCH_WIDTH; l++)
        if (fet_valid_i[l])
          mem[tail + PW'(offs[l])] <= '{instr: fet_instr_i[l],
                                        pc:    fet_addr_i[l][AWTH-1:0],
                                        ex:    fet_ex_i[l]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_pop);
      if (push) tail <= tail + PW'(n_push);
      count <= count + (push ? n_push : '0) - n_pop;
    end
  end

  for (genvar i = 0; i < DEC_WIDTH; i++) begin : g_lane
    qentry_t         ent;
    logic [IWTH-1:0] xp;
    logic            ill, is_c;
    exception_t      lane_ex;

    assign ent = mem[head + PW'(i)];

    sy_ppl_compress_dec u_dec (
      .instr_i         (ent.instr),
      .instr_o         (xp),
      .illegal_o       (ill),
      .is_compressed_o (is_c)
    );

    assign dec_valid_o[i]         = (CW'(i) < count) && !flush_i;
    assign dec_pc_o[i]            = dec_valid_o[i] ? ent.pc : '0;
    assign dec_npc_o[i]           = dec_valid_o[i] ? ent.pc + (is_c ? AWTH'(2) : AWTH'(4)) : '0;
    assign dec_instr_o[i]         = dec_valid_o[i] ? xp : '0;
    assign dec_is_compressed_o[i] = dec_valid_o[i] && is_c;
    assign dec_ex_o[i]            = lane_ex;

    // A fetch fault outranks an illegal-encoding report.
    always_comb begin
      lane_ex = '0;
      if (dec_valid_o[i]) begin
        lane_ex.valid = ent.ex || (ill && is_c);
        lane_ex.cause = ent.ex ? INSTR_PAGE_FAULT : ILLEGAL_INSTR;
        lane_ex.tval  = ent.ex ? 64'(ent.pc) : 64'(ent.instr[15:0]);
      end
    end
  end
endmodule

// File: tb/tb_sy_ppl_instr_queue_mw.sv
// Bench for sy_ppl_instr_queue_mw: a queue model tracks expected entries,
// directed vectors carry hand-computed occupancy, plus fill/wrap/flush/reset runs.
module tb_sy_ppl_instr_queue_mw;
  import sy_pkg::*;
  localparam int FW = 2, DW = 2, DEPTH = 8;

  logic                     clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic [FW-1:0]            fet_valid_i = '0, fet_ex_i = '0;
  logic [FW-1:0][63:0]      fet_addr_i = '0;
  logic [FW-1:0][31:0]      fet_instr_i = '0;
  logic                     ready_o;
  logic [DW-1:0]            dec_valid_o, dec_is_compressed_o;
  logic [DW-1:0]            dec_ready_i = '0;
  logic [DW-1:0][AWTH-1:0]  dec_pc_o, dec_npc_o;
  logic [DW-1:0][IWTH-1:0]  dec_instr_o;
  exception_t [DW-1:0]      dec_ex_o;
  logic [$clog2(DEPTH):0]   usage_o;

  sy_ppl_instr_queue_mw #(.FETCH_WIDTH(FW), .DEC_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .fet_valid_i(fet_valid_i), .fet_addr_i(fet_addr_i), .fet_instr_i(fet_instr_i),
    .fet_ex_i(fet_ex_i), .ready_o(ready_o), .dec_valid_o(dec_valid_o),
    .dec_ready_i(dec_ready_i), .dec_pc_o(dec_pc_o), .dec_npc_o(dec_npc_o),
    .dec_instr_o(dec_instr_o), .dec_is_compressed_o(dec_is_compressed_o),
    .dec_ex_o(dec_ex_o), .usage_o(usage_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] raw, xp; logic is_c, ill; } lib_t;
  typedef struct { logic [63:0] pc; logic [31:0] raw, xp; logic is_c, ill, ex; } sb_t;
  typedef struct {
    logic [1:0] v; int i0, i1; logic [63:0] p0, p1;
    logic [1:0] ex, rdy; int usage_after;
  } vec_t;

  lib_t lib [7];
  sb_t  sb [$];
  vec_t vt [13];
  int   checks = 0, errors = 0;
  logic [63:0] pc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic sb_t mk(input int li, input logic [63:0] p, input logic ex);
    return '{pc: p, raw: lib[li].raw, xp: lib[li].xp, is_c: lib[li].is_c,
             ill: lib[li].ill, ex: ex};
  endfunction

  task automatic check_lane(input int i, input sb_t e);
    logic exv;
    exv = e.ex || e.ill;
    chk($sformatf("pc%0d", i), 64'(dec_pc_o[i]), e.pc);
    chk($sformatf("npc%0d", i), 64'(dec_npc_o[i]), e.pc + (e.is_c ? 64'd2 : 64'd4));
    chk($sformatf("isc%0d", i), 64'(dec_is_compressed_o[i]), 64'(e.is_c));
    if (!e.ill) chk($sformatf("instr%0d", i), 64'(dec_instr_o[i]), 64'(e.xp));
    chk($sformatf("exv%0d", i), 64'(dec_ex_o[i].valid), 64'(exv));
    if (exv) begin
      chk($sformatf("cause%0d", i), dec_ex_o[i].cause, e.ex ? INSTR_PAGE_FAULT : ILLEGAL_INSTR);
      chk($sformatf("tval%0d", i), dec_ex_o[i].tval, e.ex ? e.pc : {48'b0, e.raw[15:0]});
    end
  endtask

  // One cycle: drive after posedge, check at negedge, update model at posedge.
  task automatic step(input logic [1:0] v, input int i0, input int i1,
                      input logic [63:0] p0, input logic [63:0] p1,
                      input logic [1:0] ex, input logic [1:0] rdy, input logic fl);
    int n, sz;
    logic run, ev, rdy_exp;
    fet_valid_i = v; fet_addr_i[0] = p0; fet_addr_i[1] = p1;
    fet_instr_i[0] = lib[i0].raw; fet_instr_i[1] = lib[i1].raw;
    fet_ex_i = ex; dec_ready_i = rdy; flush_i = fl;
    @(negedge clk_i);
    sz = sb.size();
    rdy_exp = (DEPTH - sz) >= FW;
    chk("ready", 64'(ready_o), 64'(rdy_exp));
    chk("usage", 64'(usage_o), 64'(sz));
    n = 0; run = 1'b1;
    for (int i = 0; i < DW; i++) begin
      ev = (i < sz) && !fl;
      chk($sformatf("valid%0d", i), 64'(dec_valid_o[i]), 64'(ev));
      if (ev) check_lane(i, sb[i]);
      run = run && ev && rdy[i];
      if (run) n++;
    end
    @(posedge clk_i); #1;
    if (fl) sb.delete();
    else begin
      repeat (n) void'(sb.pop_front());
      if (rdy_exp)
        for (int l = 0; l < FW; l++)
          if (v[l]) sb.push_back(mk(l == 0 ? i0 : i1, l == 0 ? p0 : p1, ex[l]));
    end
    flush_i = 1'b0;
  endtask

  task automatic idle();
    fet_valid_i = '0; dec_ready_i = '0; flush_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lib[0] = '{32'h0000_0013, 32'h0000_0013, 1'b0, 1'b0}; // nop
    lib[1] = '{32'h0000_4501, 32'h0000_0513, 1'b1, 1'b0}; // c.li a0,0
    lib[2] = '{32'h0000_0505, 32'h0015_0513, 1'b1, 1'b0}; // c.addi a0,1
    lib[3] = '{32'h0000_85AA, 32'h00A0_05B3, 1'b1, 1'b0}; // c.mv a1,a0
    lib[4] = '{32'h0000_4188, 32'h0005_A503, 1'b1, 1'b0}; // c.lw a0,0(a1)
    lib[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1}; // illegal
    lib[6] = '{32'h1234_52B7, 32'h1234_52B7, 1'b0, 1'b0}; // lui t0

    vt[0]  = '{2'b11, 0, 0, 64'h1000, 64'h1004, 2'b00, 2'b00, 2};
    vt[1]  = '{2'b00, 0, 0, 64'h0,    64'h0,    2'b00, 2'b11, 0};
    vt[2]  = '{2'b10, 0, 1, 64'h0,    64'h2002, 2'b00, 2'b00, 1};
    vt[3]  = '{2'b00, 0, 0, 64'h0,    64'h0,    2'b00, 2'b01, 0};
    vt[4]  = '{2'b11, 0, 0, 64'h1100, 64'h1104, 2'b00, 2'b00, 2};
    vt[5]  = '{2'b00, 0, 0, 64'h0,    64'h0,    2'b00, 2'b10, 2};
    vt[6]  = '{2'b00, 0, 0, 64'h0,    64'h0,    2'b00, 2'b11, 0};
    vt[7]  = '{2'b11, 0, 6, 64'h3000, 64'h3004, 2'b01, 2'b00, 2};
    vt[8]  = '{2'b00, 0, 0, 64'h0,    64'h0,    2'b00, 2'b11, 0};
    vt[9]  = '{2'b01, 5, 0, 64'h4000, 64'h0,    2'b00, 2'b00, 1};
    vt[10] = '{2'b11, 2, 3, 64'h4002, 64'h4004, 2'b00, 2'b01, 2};
    vt[11] = '{2'b01, 4, 0, 64'h4006, 64'h0,    2'b00, 2'b11, 1};
    vt[12] = '{2'b00, 0, 0, 64'h0,    64'h0,    2'b00, 2'b11, 0};

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(dec_valid_o), 64'd0);
    chk("rst_usage", 64'(usage_o), 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    foreach (vt[k]) begin
      step(vt[k].v, vt[k].i0, vt[k].i1, vt[k].p0, vt[k].p1, vt[k].ex, vt[k].rdy, 1'b0);
      chk($sformatf("vec%0d_usage", k), 64'(usage_o), 64'(vt[k].usage_after));
    end

    // Fill to 7, offer a dropped group, single-pop back to 6, drain; 3 laps wrap pointers.
    pc = 64'h8000;
    for (int lap = 0; lap < 3; lap++) begin
      while (sb.size() < 6) begin
        step(2'b11, 0, 2, pc, pc + 4, 2'b00, 2'b00, 1'b0);
        pc += 6;
      end
      step(2'b01, 1, 0, pc, 64'h0, 2'b00, 2'b00, 1'b0);
      pc += 2;
      chk("full_ready", 64'(ready_o), 64'd0);
      step(2'b11, 0, 0, pc, pc + 4, 2'b00, 2'b00, 1'b0);
      chk("drop_usage", 64'(usage_o), 64'd7);
      step(2'b00, 0, 0, 64'h0, 64'h0, 2'b00, 2'b01, 1'b0);
      chk("pop_ready", 64'(ready_o), 64'd1);
      while (sb.size() > 0) step(2'b00, 0, 0, 64'h0, 64'h0, 2'b00, 2'b11, 1'b0);
    end

    // Flush at count 5 with a full push offered in the same cycle.
    step(2'b11, 0, 0, 64'h5000, 64'h5004, 2'b00, 2'b00, 1'b0);
    step(2'b11, 0, 0, 64'h5008, 64'h500C, 2'b00, 2'b00, 1'b0);
    step(2'b01, 0, 0, 64'h5010, 64'h0,    2'b00, 2'b00, 1'b0);
    chk("pre_flush_usage", 64'(usage_o), 64'd5);
    step(2'b11, 0, 0, 64'h6000, 64'h6004, 2'b00, 2'b11, 1'b1);
    chk("flush_usage", 64'(usage_o), 64'd0);
    chk("flush_ready", 64'(ready_o), 64'd1);

    // Random mix of push/pop patterns, ready gaps, faults and rare flushes.
    pc = 64'hA000;
    for (int r = 0; r < 300; r++) begin
      step(2'($urandom_range(0, 3)), $urandom_range(0, 6), $urandom_range(0, 6),
           pc, pc + 4, ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00,
           2'($urandom_range(0, 3)), $urandom_range(0, 31) == 0);
      pc += 8;
    end

    // Asynchronous reset in mid-operation.
    step(2'b11, 0, 0, 64'h7000, 64'h7004, 2'b00, 2'b00, 1'b0);
    step(2'b11, 0, 0, 64'h7008, 64'h700C, 2'b00, 2'b00, 1'b0);
    idle();
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_usage", 64'(usage_o), 64'd0);
    chk("arst_valid", 64'(dec_valid_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd1);
    sb.delete();
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    step(2'b01, 1, 0, 64'h9000, 64'h0, 2'b00, 2'b00, 1'b0);
    step(2'b00, 0, 0, 64'h0, 64'h0, 2'b00, 2'b11, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
